// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
//
// Purpose: FSM state encoding, port identifiers and the request record used
// by dmem_arbiter to carry the winning port's command to the memory.
// Ports: none (package).

package dmem_pkg;

    // Widest address/data the request record can carry; instances narrower
    // than this zero-extend into it and truncate back out.
    localparam int DMEM_AW = 32;
    localparam int DMEM_DW = 32;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } dmem_arb_state_t;

    typedef struct packed {
        logic                we;
        logic [DMEM_AW-1:0]  addr;
        logic [DMEM_DW-1:0]  wdata;
    } dmem_req_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Read latency as loaded into the 3-bit wait counter.
    function automatic logic [2:0] rd_lat_cnt(input int lat);
        return 3'(lat);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between requesters, arbiter and data memory
//
// Purpose: groups both requester ports and the memory-side strobes.
// Ports (signals):
//   p0_*/p1_*  : req, we, addr, wdata (to arbiter); gnt, rvalid, rdata (from arbiter)
//   mem_*      : addr, wdata, we, re (from arbiter); rdata (from memory)
// Modports: slave = arbiter view, master = requesters + memory view.

interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          p0_req;
    logic          p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;

    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - combinational two-way round-robin / fixed-priority arbiter
//
// Purpose: picks one of two requesters when enabled.
// Ports:
//   req[1:0]   in  : request per port (bit n = port n)
//   last_win   in  : port that won the previous grant
//   fixed_prio in  : 1 = port 0 wins ties, 0 = alternate on ties
//   en         in  : arbitration allowed this cycle
//   gnt[1:0]   out : one-hot grant, all zero when disabled or idle
//   win        out : index of the granted port (0 when nothing granted)

module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_win,
    input  logic       fixed_prio,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       win
);

    always_comb begin
        win = 1'b0;
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   win = 1'b0;
                2'b10:   win = 1'b1;
                // Tie: in round-robin mode the port that did not win last goes.
                2'b11:   win = fixed_prio ? 1'b0 : ~last_win;
                default: win = 1'b0;
            endcase
            if (req != 2'b00) begin
                gnt = win ? 2'b10 : 2'b01;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one single-port data memory between two requesters
//
// Purpose: arbitrates read/write requests from port 0 (core LSU) and port 1
// (debug/DMA loader), drives the memory strobes for the winner and returns
// read data to the port that issued the read after RD_LAT cycles.
// Ports:
//   clk  in : clock, rising edge
//   rst  in : synchronous active-high reset
//   bus     : dmem_arbiter_if.slave (requester handshakes + memory strobes)

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_lat
        $error("dmem_arbiter: RD_LAT must be within 1..7");
    end
    if (AW > DMEM_AW || DW > DMEM_DW) begin : g_bad_width
        $error("dmem_arbiter: AW/DW wider than the request record");
    end

    localparam logic [2:0] LAT_CNT = rd_lat_cnt(RD_LAT);
    localparam logic       FIXED   = (FIXED_PRIO != 0);

    dmem_arb_state_t state, state_nxt;
    logic [2:0]      rd_cnt, rd_cnt_nxt;
    logic            rd_owner, rd_owner_nxt;
    logic            last_win, last_win_nxt;

    logic            rd_last;
    logic            issue_ok;
    logic            issue;
    logic [1:0]      arb_gnt;
    logic            win;
    dmem_req_t       req0, req1, win_req;

    // Final wait cycle of an outstanding read: data is returned and the
    // memory is free again, so a new command may issue in the same cycle.
    assign rd_last  = (state == RD_WAIT) && (rd_cnt == 3'd1);
    assign issue_ok = (state == IDLE) || rd_last;

    rr_arb2 u_arb (
        .req        ({bus.p1_req, bus.p0_req}),
        .last_win   (last_win),
        .fixed_prio (FIXED),
        .en         (issue_ok),
        .gnt        (arb_gnt),
        .win        (win)
    );

    assign issue = |arb_gnt;

    always_comb begin
        req0    = '{we: bus.p0_we, addr: DMEM_AW'(bus.p0_addr), wdata: DMEM_DW'(bus.p0_wdata)};
        req1    = '{we: bus.p1_we, addr: DMEM_AW'(bus.p1_addr), wdata: DMEM_DW'(bus.p1_wdata)};
        win_req = (win == PORT1) ? req1 : req0;
    end

    // Memory strobes and grants: all zero outside an issue cycle.
    always_comb begin
        bus.p0_gnt    = arb_gnt[0];
        bus.p1_gnt    = arb_gnt[1];
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (issue) begin
            bus.mem_we    = win_req.we;
            bus.mem_re    = ~win_req.we;
            bus.mem_addr  = AW'(win_req.addr);
            bus.mem_wdata = DW'(win_req.wdata);
        end
    end

    // Read return: memory data is forwarded combinationally to the owner only.
    always_comb begin
        bus.p0_rvalid = rd_last && (rd_owner == PORT0);
        bus.p1_rvalid = rd_last && (rd_owner == PORT1);
        bus.p0_rdata  = bus.p0_rvalid ? bus.mem_rdata : '0;
        bus.p1_rdata  = bus.p1_rvalid ? bus.mem_rdata : '0;
    end

    always_comb begin
        state_nxt    = state;
        rd_cnt_nxt   = rd_cnt;
        rd_owner_nxt = rd_owner;
        last_win_nxt = last_win;

        if (state == RD_WAIT) begin
            rd_cnt_nxt = rd_cnt - 3'd1;
            if (rd_last) begin
                state_nxt = IDLE;
            end
        end

        if (issue) begin
            last_win_nxt = win;
            // A read issued on the final wait cycle reloads RD_WAIT directly.
            if (!win_req.we) begin
                state_nxt    = RD_WAIT;
                rd_cnt_nxt   = LAT_CNT;
                rd_owner_nxt = win;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rd_cnt   <= 3'd0;
            rd_owner <= PORT0;
            // Pretend port 1 won last so port 0 takes the first tie.
            last_win <= PORT1;
        end else begin
            state    <= state_nxt;
            rd_cnt   <= rd_cnt_nxt;
            rd_owner <= rd_owner_nxt;
            last_win <= last_win_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter (three configurations)

module tb_dmem_arbiter;

    typedef struct packed {
        logic        rst;
        logic        p0_req;
        logic        p0_we;
        logic [31:0] p0_addr;
        logic [31:0] p0_wdata;
        logic        p1_req;
        logic        p1_we;
        logic [31:0] p1_addr;
        logic [31:0] p1_wdata;
    } in_t;

    typedef struct packed {
        logic        p0_gnt;
        logic        p0_rvalid;
        logic [31:0] p0_rdata;
        logic        p1_gnt;
        logic        p1_rvalid;
        logic [31:0] p1_rdata;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        mem_we;
        logic        mem_re;
    } out_t;

    typedef struct {
        in_t  x;
        int   sel;
        out_t o;
    } vec_t;

    logic        clk;
    logic        rst;
    in_t         cur;
    logic [31:0] mrd [3];
    out_t        obs [3];

    int vectors;
    int miscompares;

    // DUT 0: RD_LAT=1 round-robin; DUT 1: RD_LAT=3 round-robin; DUT 2: RD_LAT=1 fixed priority.
    int lat  [3] = '{1, 3, 1};
    bit fixd [3] = '{1'b0, 1'b0, 1'b1};

    // Reference model state: an outstanding read is described by the cycle
    // number on which its data is due, rather than by a countdown.
    int          cyc;
    bit          m_pend [3];
    int          m_due  [3];
    bit          m_own  [3];
    bit          m_last [3];
    logic [31:0] m_rdv  [3];
    logic [31:0] memv   [3][16];

    dmem_arbiter_if #(.AW(32), .DW(32)) ia ();
    dmem_arbiter_if #(.AW(32), .DW(32)) ib ();
    dmem_arbiter_if #(.AW(32), .DW(32)) ic ();

    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .FIXED_PRIO(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .FIXED_PRIO(0)) dut_b (.clk(clk), .rst(rst), .bus(ib));
    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .FIXED_PRIO(1)) dut_c (.clk(clk), .rst(rst), .bus(ic));

    assign rst = cur.rst;

    assign ia.p0_req = cur.p0_req;  assign ia.p0_we = cur.p0_we;
    assign ia.p0_addr = cur.p0_addr; assign ia.p0_wdata = cur.p0_wdata;
    assign ia.p1_req = cur.p1_req;  assign ia.p1_we = cur.p1_we;
    assign ia.p1_addr = cur.p1_addr; assign ia.p1_wdata = cur.p1_wdata;
    assign ia.mem_rdata = mrd[0];
    assign ib.p0_req = cur.p0_req;  assign ib.p0_we = cur.p0_we;
    assign ib.p0_addr = cur.p0_addr; assign ib.p0_wdata = cur.p0_wdata;
    assign ib.p1_req = cur.p1_req;  assign ib.p1_we = cur.p1_we;
    assign ib.p1_addr = cur.p1_addr; assign ib.p1_wdata = cur.p1_wdata;
    assign ib.mem_rdata = mrd[1];
    assign ic.p0_req = cur.p0_req;  assign ic.p0_we = cur.p0_we;
    assign ic.p0_addr = cur.p0_addr; assign ic.p0_wdata = cur.p0_wdata;
    assign ic.p1_req = cur.p1_req;  assign ic.p1_we = cur.p1_we;
    assign ic.p1_addr = cur.p1_addr; assign ic.p1_wdata = cur.p1_wdata;
    assign ic.mem_rdata = mrd[2];

    assign obs[0] = {ia.p0_gnt, ia.p0_rvalid, ia.p0_rdata, ia.p1_gnt, ia.p1_rvalid, ia.p1_rdata,
                     ia.mem_addr, ia.mem_wdata, ia.mem_we, ia.mem_re};
    assign obs[1] = {ib.p0_gnt, ib.p0_rvalid, ib.p0_rdata, ib.p1_gnt, ib.p1_rvalid, ib.p1_rdata,
                     ib.mem_addr, ib.mem_wdata, ib.mem_we, ib.mem_re};
    assign obs[2] = {ic.p0_gnt, ic.p0_rvalid, ic.p0_rdata, ic.p1_gnt, ic.p1_rvalid, ic.p1_rdata,
                     ic.mem_addr, ic.mem_wdata, ic.mem_we, ic.mem_re};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic in_t mk_in(bit r, bit r0, bit w0, logic [31:0] a0, logic [31:0] d0,
                                  bit r1, bit w1, logic [31:0] a1, logic [31:0] d1);
        return '{rst: r, p0_req: r0, p0_we: w0, p0_addr: a0, p0_wdata: d0,
                 p1_req: r1, p1_we: w1, p1_addr: a1, p1_wdata: d1};
    endfunction

    function automatic out_t mk_out(bit g0, bit v0, logic [31:0] rd0, bit g1, bit v1, logic [31:0] rd1,
                                    logic [31:0] ma, logic [31:0] mw, bit we, bit re);
        return '{p0_gnt: g0, p0_rvalid: v0, p0_rdata: rd0, p1_gnt: g1, p1_rvalid: v1, p1_rdata: rd1,
                 mem_addr: ma, mem_wdata: mw, mem_we: we, mem_re: re};
    endfunction

    // Expected outputs of configuration k for the current cycle and inputs.
    function automatic out_t model_out(int k, in_t x, output bit iss, output bit w);
        out_t o   = '0;
        bit   due = m_pend[k] && (cyc == m_due[k]);
        bit   ok  = !m_pend[k] || due;
        if (due) begin
            if (m_own[k]) begin o.p1_rvalid = 1'b1; o.p1_rdata = m_rdv[k]; end
            else          begin o.p0_rvalid = 1'b1; o.p0_rdata = m_rdv[k]; end
        end
        iss = ok && (x.p0_req || x.p1_req);
        if (x.p0_req && x.p1_req) w = fixd[k] ? 1'b0 : !m_last[k];
        else                      w = x.p1_req;
        if (iss) begin
            if (w) o.p1_gnt = 1'b1; else o.p0_gnt = 1'b1;
            o.mem_addr  = w ? x.p1_addr  : x.p0_addr;
            o.mem_wdata = w ? x.p1_wdata : x.p0_wdata;
            o.mem_we    = w ? x.p1_we    : x.p0_we;
            o.mem_re    = !o.mem_we;
        end
        return o;
    endfunction

    function automatic void model_step(int k, in_t x);
        bit   iss, w;
        out_t o   = model_out(k, x, iss, w);
        bit   due = m_pend[k] && (cyc == m_due[k]);
        if (x.rst) begin
            m_pend[k] = 1'b0;
            m_own[k]  = 1'b0;
            m_last[k] = 1'b1;
        end else begin
            if (due) m_pend[k] = 1'b0;
            if (iss) begin
                m_last[k] = w;
                if (o.mem_we) begin
                    memv[k][o.mem_addr[5:2]] = o.mem_wdata;
                end else begin
                    m_pend[k] = 1'b1;
                    m_due[k]  = cyc + lat[k];
                    m_own[k]  = w;
                    m_rdv[k]  = memv[k][o.mem_addr[5:2]];
                end
            end
        end
    endfunction

    task automatic check(string nm, out_t act, out_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, compare all three DUTs against the model (and
    // optionally one DUT against a hand-written table entry), then advance.
    task automatic run_cycle(in_t x, bit tbl_en, int sel, out_t texp, string nm);
        bit   iss, w;
        out_t e;
        cur = x;
        for (int k = 0; k < 3; k++) begin
            // The memory returns data only on the due cycle; junk otherwise.
            if (m_pend[k] && cyc == m_due[k]) mrd[k] = m_rdv[k];
            else                              mrd[k] = {16'hbad0, 16'(cyc)};
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            e = model_out(k, x, iss, w);
            check($sformatf("model_dut%0d_cyc%0d", k, cyc), obs[k], e);
        end
        if (tbl_en) check(nm, obs[sel], texp);
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_step(k, x);
        cyc++;
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        in_t  idl, rs, bw, rx;
        out_t z;
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        for (int k = 0; k < 3; k++) begin
            m_pend[k] = 1'b0; m_due[k] = 0; m_own[k] = 1'b0; m_last[k] = 1'b1; m_rdv[k] = '0;
            for (int j = 0; j < 16; j++) memv[k][j] = '0;
            mrd[k] = '0;
        end

        idl = mk_in(0, 0,0,0,0, 0,0,0,0);
        rs  = mk_in(1, 0,0,0,0, 0,0,0,0);
        bw  = mk_in(0, 1,1,20,1, 1,1,24,2);
        z   = '0;

        // Reset and idle
        tbl.push_back('{rs,  0, z});
        tbl.push_back('{rs,  1, z});
        tbl.push_back('{idl, 0, z});
        tbl.push_back('{idl, 1, z});
        tbl.push_back('{idl, 2, z});
        tbl.push_back('{idl, 0, z});
        tbl.push_back('{idl, 1, z});
        // Port 0 write then read-back, RD_LAT=1 and RD_LAT=3
        tbl.push_back('{mk_in(0, 1,1,5,10, 0,0,0,0), 0, mk_out(1,0,0, 0,0,0, 5,10,1,0)});
        tbl.push_back('{mk_in(0, 1,0,5,0,  0,0,0,0), 0, mk_out(1,0,0, 0,0,0, 5,0,0,1)});
        tbl.push_back('{idl, 0, mk_out(0,1,10, 0,0,0, 0,0,0,0)});
        tbl.push_back('{idl, 1, z});
        tbl.push_back('{idl, 1, mk_out(0,1,10, 0,0,0, 0,0,0,0)});
        // Both write: round-robin alternates (port 0 won last), fixed keeps port 0
        tbl.push_back('{bw, 0, mk_out(0,0,0, 1,0,0, 24,2,1,0)});
        tbl.push_back('{bw, 0, mk_out(1,0,0, 0,0,0, 20,1,1,0)});
        tbl.push_back('{bw, 0, mk_out(0,0,0, 1,0,0, 24,2,1,0)});
        tbl.push_back('{bw, 0, mk_out(1,0,0, 0,0,0, 20,1,1,0)});
        tbl.push_back('{bw, 2, mk_out(1,0,0, 0,0,0, 20,1,1,0)});
        tbl.push_back('{bw, 2, mk_out(1,0,0, 0,0,0, 20,1,1,0)});
        tbl.push_back('{mk_in(0, 0,0,0,0, 1,1,24,2), 2, mk_out(0,0,0, 1,0,0, 24,2,1,0)});
        // RD_LAT=3: p1 read blocks p0 write until the final wait cycle
        tbl.push_back('{mk_in(0, 0,0,0,0, 1,0,20,0), 1, mk_out(0,0,0, 1,0,0, 20,0,0,1)});
        rx = mk_in(0, 1,1,8,7, 0,0,0,0);
        tbl.push_back('{rx, 1, z});
        tbl.push_back('{rx, 1, z});
        tbl.push_back('{rx, 1, mk_out(1,0,0, 0,1,1, 8,7,1,0)});
        // RD_LAT=3: read abandoned by reset, next request granted from IDLE
        tbl.push_back('{mk_in(0, 1,0,8,0, 0,0,0,0), 1, mk_out(1,0,0, 0,0,0, 8,0,0,1)});
        tbl.push_back('{rs, 1, z});
        tbl.push_back('{mk_in(0, 0,0,0,0, 1,1,12,3), 1, mk_out(0,0,0, 1,0,0, 12,3,1,0)});
        tbl.push_back('{idl, 1, z});
        tbl.push_back('{idl, 1, z});
        tbl.push_back('{idl, 1, z});

        // One unchecked reset edge so every DUT starts from a known state.
        cur = rs;
        @(posedge clk);
        #1;

        for (int r = 0; r < tbl.size(); r++) begin
            run_cycle(tbl[r].x, 1'b1, tbl[r].sel, tbl[r].o, $sformatf("tbl%0d_dut%0d", r, tbl[r].sel));
        end

        for (int n = 0; n < 900; n++) begin
            in_t x;
            x.rst      = ($urandom_range(0, 63) == 0);
            x.p0_req   = ($urandom_range(0, 3) != 0);
            x.p0_we    = $urandom_range(0, 1) == 1;
            x.p0_addr  = $urandom();
            x.p0_wdata = $urandom();
            x.p1_req   = ($urandom_range(0, 3) != 0);
            x.p1_we    = $urandom_range(0, 1) == 1;
            x.p1_addr  = $urandom();
            x.p1_wdata = $urandom();
            run_cycle(x, 1'b0, 0, z, "");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
